sale_terminal_controller: RTL and testbench

SALE_TERMINAL_CONTROLLER -- requirements
Module: sale_terminal_controller

---
 rtl/sale_terminal_pkg.sv | 40 ++++
 rtl/sale_terminal_controller_key_decoder.sv | 22 ++
 rtl/sale_terminal_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_sale_terminal_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sale_terminal_pkg.sv
// Shared types and codes for the sale terminal: FSM states, error codes,
// basket operations and cursor direction codes.
package sale_terminal_pkg;

    typedef enum logic [3:0] {
        ST_START    = 4'd0,
        ST_IDLE     = 4'd1,
        ST_BARCODE  = 4'd2,
        ST_INTERACT = 4'd3,
        ST_QTY      = 4'd4,
        ST_COMMIT   = 4'd5,
        ST_EDIT     = 4'd6,
        ST_ERROR    = 4'd7,
        ST_END      = 4'd8
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INVALID = 2'b01;
    localparam logic [1:0] ERR_FULL    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_REMOVE = 1'b1;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Key 0 moves right, key 3 moves left; callers screen out keys above 3.
    function automatic logic [1:0] key_to_dir(input logic [31:0] idx);
        case (idx)
            32'd0:   key_to_dir = DIR_RIGHT;
            32'd1:   key_to_dir = DIR_DOWN;
            32'd2:   key_to_dir = DIR_UP;
            default: key_to_dir = DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/sale_terminal_controller_key_decoder.sv
// Priority key decoder: lowest set key wins; purely combinational, no flow control.
module key_decoder #(
    parameter int NUM_KEYS = 4,
    parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic                key_vld_o,
    output logic [IDX_W-1:0]    key_idx_o
);

    always_comb begin
        key_vld_o = 1'b0;
        key_idx_o = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (keys_i[i]) begin
                key_vld_o = 1'b1;
                key_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sale_terminal_controller.sv
// Sale session controller: barcode/cursor product pick, quantity entry, basket add/remove.
// All outputs registered (one-cycle latency); basket_req is held until basket_ack is sampled.
module sale_terminal_controller #(
    parameter int NUM_KEYS     = 4,
    parameter int DIGITS       = 4,
    parameter int DIGIT_W      = 4,
    parameter int ID_W         = 4,
    parameter int QTY_W        = 4,
    parameter int BASKET_DEPTH = 8,
    parameter int QTY_TIMEOUT  = 500_000_000,
    parameter int ERR_HOLD     = 100_000_000
) (
    input  logic                                CLOCK_50,
    input  logic                                RESET,
    input  logic                                cmd_select,
    input  logic [NUM_KEYS-1:0]                 key_pulse,
    input  logic                                sw_interactive,
    input  logic                                sw_edit,
    input  logic                                barcode_complete,
    input  logic                                product_valid,
    input  logic [ID_W-1:0]                     product_id_bc,
    input  logic [ID_W-1:0]                     product_id_dir,
    input  logic [$clog2(BASKET_DEPTH+1)-1:0]   basket_count,
    input  logic                                basket_ack,
    output logic [3:0]                          state_o,
    output logic [DIGIT_W-1:0]                  digit_out,
    output logic                                digit_push,
    output logic                                barcode_clear,
    output logic [1:0]                          dir_out,
    output logic                                dir_en,
    output logic                                dir_clear,
    output logic                                basket_req,
    output logic                                basket_op,
    output logic [ID_W-1:0]                     product_id_out,
    output logic [QTY_W-1:0]                    quantity_out,
    output logic [1:0]                          err_code,
    output logic                                end_shopping
);
    import sale_terminal_pkg::*;

    localparam int IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CNT_W     = $clog2(BASKET_DEPTH + 1);
    localparam int TMR_MAX   = (QTY_TIMEOUT > ERR_HOLD) ? QTY_TIMEOUT : ERR_HOLD;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam bit DIGITS_EN = (DIGITS > 0);

    state_e             state_q;
    logic [TMR_W-1:0]   timer_q;
    logic               ret_edit_q;
    logic [DIGIT_W-1:0] digit_q;
    logic               digit_push_q;
    logic               barcode_clear_q;
    logic [1:0]         dir_q;
    logic               dir_en_q;
    logic               dir_clear_q;
    logic               basket_req_q;
    logic               basket_op_q;
    logic [ID_W-1:0]    product_id_q;
    logic [QTY_W-1:0]   quantity_q;
    logic [1:0]         err_q;
    logic               end_shopping_q;

    logic               key_vld;
    logic [IDX_W-1:0]   key_idx;
    logic [DIGIT_W-1:0] digit_val;
    logic [QTY_W-1:0]   qty_val;
    logic               dir_key_vld;
    logic [1:0]         dir_val;
    logic               bskt_full;
    logic               bskt_empty;
    logic               qty_expired;
    logic               hold_expired;
    logic [TMR_W-1:0]   timer_inc;

    key_decoder #(
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_key_decoder (
        .keys_i    (key_pulse),
        .key_vld_o (key_vld),
        .key_idx_o (key_idx)
    );

    assign digit_val    = DIGIT_W'(key_idx) + DIGIT_W'(1);
    assign qty_val      = QTY_W'(key_idx) + QTY_W'(1);
    assign dir_key_vld  = key_vld && (32'(key_idx) < 32'd4);
    assign dir_val      = key_to_dir(32'(key_idx));
    assign bskt_full    = (basket_count == CNT_W'(BASKET_DEPTH));
    assign bskt_empty   = (basket_count == '0);
    assign qty_expired  = (timer_q == TMR_W'(QTY_TIMEOUT - 1));
    assign hold_expired = (timer_q == TMR_W'(ERR_HOLD - 1));
    assign timer_inc    = (&timer_q) ? timer_q : timer_q + TMR_W'(1);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q         <= ST_START;
            timer_q         <= '0;
            ret_edit_q      <= 1'b0;
            digit_q         <= '0;
            digit_push_q    <= 1'b0;
            barcode_clear_q <= 1'b0;
            dir_q           <= 2'b00;
            dir_en_q        <= 1'b0;
            dir_clear_q     <= 1'b0;
            basket_req_q    <= 1'b0;
            basket_op_q     <= 1'b0;
            product_id_q    <= '0;
            quantity_q      <= '0;
            err_q           <= ERR_NONE;
            end_shopping_q  <= 1'b0;
        end else begin
            digit_push_q    <= 1'b0;
            barcode_clear_q <= 1'b0;
            dir_en_q        <= 1'b0;
            dir_clear_q     <= 1'b0;
            end_shopping_q  <= 1'b0;

            case (state_q)
                ST_START: begin
                    barcode_clear_q <= 1'b1;
                    dir_clear_q     <= 1'b1;
                    err_q           <= ERR_NONE;
                    state_q         <= ST_IDLE;
                end

                ST_IDLE: begin
                    if (cmd_select)          state_q <= ST_END;
                    else if (sw_edit)        state_q <= ST_EDIT;
                    else if (sw_interactive) state_q <= ST_INTERACT;
                    else                     state_q <= ST_BARCODE;
                end

                ST_BARCODE: begin
                    if (sw_interactive || sw_edit) begin
                        state_q <= ST_IDLE;
                    end else if (key_vld && !barcode_complete && DIGITS_EN) begin
                        digit_push_q <= 1'b1;
                        digit_q      <= digit_val;
                    end else if (cmd_select && barcode_complete) begin
                        timer_q <= '0;
                        if (product_valid) begin
                            product_id_q <= product_id_bc;
                            state_q      <= ST_QTY;
                        end else begin
                            barcode_clear_q <= 1'b1;
                            err_q           <= ERR_INVALID;
                            state_q         <= ST_ERROR;
                        end
                    end
                end

                ST_INTERACT: begin
                    if (!sw_interactive) begin
                        dir_clear_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else if (cmd_select) begin
                        product_id_q <= product_id_dir;
                        dir_clear_q  <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= ST_QTY;
                    end else if (dir_key_vld) begin
                        dir_en_q <= 1'b1;
                        dir_q    <= dir_val;
                    end
                end

                // A full basket is rejected before any quantity wait; a key beats expiry.
                ST_QTY: begin
                    if (bskt_full) begin
                        err_q   <= ERR_FULL;
                        timer_q <= '0;
                        state_q <= ST_ERROR;
                    end else if (key_vld) begin
                        quantity_q   <= qty_val;
                        basket_op_q  <= OP_ADD;
                        basket_req_q <= 1'b1;
                        ret_edit_q   <= 1'b0;
                        state_q      <= ST_COMMIT;
                    end else if (qty_expired) begin
                        err_q   <= ERR_TIMEOUT;
                        timer_q <= '0;
                        state_q <= ST_ERROR;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end

                ST_COMMIT: begin
                    if (basket_ack) begin
                        basket_req_q    <= 1'b0;
                        barcode_clear_q <= 1'b1;
                        state_q         <= ret_edit_q ? ST_EDIT : ST_IDLE;
                    end
                end

                ST_EDIT: begin
                    if (!sw_edit) begin
                        state_q <= ST_IDLE;
                    end else if (cmd_select && !bskt_empty) begin
                        product_id_q <= product_id_dir;
                        quantity_q   <= '0;
                        basket_op_q  <= OP_REMOVE;
                        basket_req_q <= 1'b1;
                        ret_edit_q   <= 1'b1;
                        state_q      <= ST_COMMIT;
                    end else if (dir_key_vld) begin
                        dir_en_q <= 1'b1;
                        dir_q    <= dir_val;
                    end
                end

                ST_ERROR: begin
                    if (cmd_select || hold_expired) begin
                        err_q   <= ERR_NONE;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end

                ST_END: begin
                    end_shopping_q <= 1'b1;
                    state_q        <= ST_START;
                end

                default: state_q <= ST_START;
            endcase
        end
    end

    assign state_o        = state_q;
    assign digit_out      = digit_q;
    assign digit_push     = digit_push_q;
    assign barcode_clear  = barcode_clear_q;
    assign dir_out        = dir_q;
    assign dir_en         = dir_en_q;
    assign dir_clear      = dir_clear_q;
    assign basket_req     = basket_req_q;
    assign basket_op      = basket_op_q;
    assign product_id_out = product_id_q;
    assign quantity_out   = quantity_q;
    assign err_code       = err_q;
    assign end_shopping   = end_shopping_q;

endmodule

// File: tb/tb_sale_terminal_controller.sv
// Bench for sale_terminal_controller: directed vector table, corner-case sequences,
// then random stimulus against a behavioural session model.
module tb_sale_terminal_controller;

    localparam int NK = 4;
    localparam int BD = 8;
    localparam int QT = 8;
    localparam int EH = 5;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic       cmd_select;
    logic [3:0] key_pulse;
    logic       sw_interactive;
    logic       sw_edit;
    logic       barcode_complete;
    logic       product_valid;
    logic [3:0] product_id_bc;
    logic [3:0] product_id_dir;
    logic [3:0] basket_count;
    logic       basket_ack;
    logic [3:0] state_o;
    logic [3:0] digit_out;
    logic       digit_push;
    logic       barcode_clear;
    logic [1:0] dir_out;
    logic       dir_en;
    logic       dir_clear;
    logic       basket_req;
    logic       basket_op;
    logic [3:0] product_id_out;
    logic [3:0] quantity_out;
    logic [1:0] err_code;
    logic       end_shopping;

    sale_terminal_controller #(
        .NUM_KEYS(NK), .DIGITS(4), .DIGIT_W(4), .ID_W(4), .QTY_W(4),
        .BASKET_DEPTH(BD), .QTY_TIMEOUT(QT), .ERR_HOLD(EH)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .cmd_select(cmd_select),
        .key_pulse(key_pulse), .sw_interactive(sw_interactive), .sw_edit(sw_edit),
        .barcode_complete(barcode_complete), .product_valid(product_valid),
        .product_id_bc(product_id_bc), .product_id_dir(product_id_dir),
        .basket_count(basket_count), .basket_ack(basket_ack),
        .state_o(state_o), .digit_out(digit_out), .digit_push(digit_push),
        .barcode_clear(barcode_clear), .dir_out(dir_out), .dir_en(dir_en),
        .dir_clear(dir_clear), .basket_req(basket_req), .basket_op(basket_op),
        .product_id_out(product_id_out), .quantity_out(quantity_out),
        .err_code(err_code), .end_shopping(end_shopping)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] digit;
        logic       dpush;
        logic       bclr;
        logic [1:0] dir;
        logic       den;
        logic       dclr;
        logic       breq;
        logic       bop;
        logic [3:0] pid;
        logic [3:0] qty;
        logic [1:0] err;
        logic       endsh;
    } outs_t;

    typedef struct {
        logic       cmd, swi, swe, comp, valid, ack;
        logic [3:0] keys, bcnt;
        logic [3:0] e_state;
        logic [4:0] e_strb;   // {digit_push, barcode_clear, dir_en, dir_clear, end_shopping}
        logic       e_breq, e_bop;
        logic [3:0] e_qty, e_pid;
        logic [1:0] e_err;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    outs_t m;
    int    m_st;
    int    m_dwell;
    bit    m_back_edit;
    vec_t  vq[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o = '{state_o, digit_out, digit_push, barcode_clear, dir_out, dir_en, dir_clear,
              basket_req, basket_op, product_id_out, quantity_out, err_code, end_shopping};
        return o;
    endfunction

    // Session rules, one clock at a time; states numbered 0..8 as START..END.
    task automatic model_clock();
        int k;
        k = -1;
        for (int i = NK - 1; i >= 0; i--) if (key_pulse[i]) k = i;
        m.dpush = 0; m.bclr = 0; m.den = 0; m.dclr = 0; m.endsh = 0;
        if (RESET) begin
            m = '0; m_st = 0; m_dwell = 0; m_back_edit = 0;
        end else begin
            case (m_st)
                0: begin m.bclr = 1; m.dclr = 1; m.err = 0; m_st = 1; end
                1: m_st = cmd_select ? 8 : sw_edit ? 6 : sw_interactive ? 3 : 2;
                2: if (sw_interactive || sw_edit) m_st = 1;
                   else if (k >= 0 && !barcode_complete) begin m.dpush = 1; m.digit = 4'(k + 1); end
                   else if (cmd_select && barcode_complete) begin
                       m_dwell = 0;
                       if (product_valid) begin m.pid = product_id_bc; m_st = 4; end
                       else begin m.bclr = 1; m.err = 1; m_st = 7; end
                   end
                3: if (!sw_interactive) begin m.dclr = 1; m_st = 1; end
                   else if (cmd_select) begin m.pid = product_id_dir; m.dclr = 1; m_dwell = 0; m_st = 4; end
                   else if (k >= 0 && k < 4) begin m.den = 1; m.dir = 2'(3 - k); end
                4: if (int'(basket_count) == BD) begin m.err = 2; m_dwell = 0; m_st = 7; end
                   else if (k >= 0) begin m.qty = 4'(k + 1); m.bop = 0; m.breq = 1; m_back_edit = 0; m_st = 5; end
                   else if (m_dwell == QT - 1) begin m.err = 3; m_dwell = 0; m_st = 7; end
                   else m_dwell++;
                5: if (basket_ack) begin m.breq = 0; m.bclr = 1; m_st = m_back_edit ? 6 : 1; end
                6: if (!sw_edit) m_st = 1;
                   else if (cmd_select && basket_count != 0) begin
                       m.pid = product_id_dir; m.qty = 0; m.bop = 1; m.breq = 1; m_back_edit = 1; m_st = 5;
                   end else if (k >= 0 && k < 4) begin m.den = 1; m.dir = 2'(3 - k); end
                7: if (cmd_select || m_dwell == EH - 1) begin m.err = 0; m_st = 1; end
                   else m_dwell++;
                default: begin m.endsh = 1; m_st = 0; end
            endcase
        end
        m.state = 4'(m_st);
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_clock();
        @(negedge CLOCK_50);
        cyc++;
        chk("outputs_vs_model", 64'(dut_outs()), 64'(m));
    endtask

    task automatic idle_inputs();
        RESET = 0; cmd_select = 0; key_pulse = 0; sw_interactive = 0; sw_edit = 0;
        barcode_complete = 0; product_valid = 0; basket_ack = 0;
        product_id_bc = 4'hA; product_id_dir = 4'h5; basket_count = 4'd1;
    endtask

    function automatic vec_t v(input logic cmd, swi, swe, comp, valid, ack,
                               input logic [3:0] keys, bcnt, e_state, input logic [4:0] e_strb,
                               input logic e_breq, e_bop, input logic [3:0] e_qty, e_pid,
                               input logic [1:0] e_err);
        vec_t r;
        r = '{cmd, swi, swe, comp, valid, ack, keys, bcnt, e_state, e_strb, e_breq, e_bop, e_qty, e_pid, e_err};
        return r;
    endfunction

    initial begin
        m = '0; m_st = 0; m_dwell = 0; m_back_edit = 0;
        idle_inputs();
        RESET = 1;
        step(); step();
        chk("reset_state", 64'(dut_outs()), 64'd0);
        RESET = 0;

        //       cmd swi swe cmp vld ack keys bcnt  st strobes  breq bop qty  pid  err
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 1,5'b01010, 0,0,4'd0,4'h0,2'd0)); // START -> IDLE
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 2,5'b00000, 0,0,4'd0,4'h0,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h1,1, 2,5'b10000, 0,0,4'd0,4'h0,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h2,1, 2,5'b10000, 0,0,4'd0,4'h0,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h4,1, 2,5'b10000, 0,0,4'd0,4'h0,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h8,1, 2,5'b10000, 0,0,4'd0,4'h0,2'd0));
        vq.push_back(v(0,0,0,1,1,0, 4'h1,1, 2,5'b00000, 0,0,4'd0,4'h0,2'd0)); // key after complete ignored
        vq.push_back(v(1,0,0,1,1,0, 4'h0,1, 4,5'b00000, 0,0,4'd0,4'hA,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h4,1, 5,5'b00000, 1,0,4'd3,4'hA,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 5,5'b00000, 1,0,4'd3,4'hA,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 5,5'b00000, 1,0,4'd3,4'hA,2'd0));
        vq.push_back(v(0,0,0,0,0,1, 4'h0,1, 1,5'b01000, 0,0,4'd3,4'hA,2'd0)); // ack on third cycle
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 2,5'b00000, 0,0,4'd3,4'hA,2'd0));
        vq.push_back(v(0,0,1,0,0,0, 4'h0,1, 1,5'b00000, 0,0,4'd3,4'hA,2'd0));
        vq.push_back(v(0,0,1,0,0,0, 4'h0,1, 6,5'b00000, 0,0,4'd3,4'hA,2'd0));
        vq.push_back(v(1,0,1,0,0,0, 4'h0,2, 5,5'b00000, 1,1,4'd0,4'h5,2'd0)); // remove request
        vq.push_back(v(0,0,1,0,0,1, 4'h0,2, 6,5'b01000, 0,1,4'd0,4'h5,2'd0));
        vq.push_back(v(1,0,1,0,0,0, 4'h0,0, 6,5'b00000, 0,1,4'd0,4'h5,2'd0)); // empty basket: ignored
        vq.push_back(v(0,0,1,0,0,0, 4'h1,0, 6,5'b00100, 0,1,4'd0,4'h5,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 1,5'b00000, 0,1,4'd0,4'h5,2'd0));
        vq.push_back(v(1,0,0,0,0,0, 4'h0,1, 8,5'b00000, 0,1,4'd0,4'h5,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 0,5'b00001, 0,1,4'd0,4'h5,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 1,5'b01010, 0,1,4'd0,4'h5,2'd0));
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 2,5'b00000, 0,1,4'd0,4'h5,2'd0));
        vq.push_back(v(1,0,0,1,0,0, 4'h0,1, 7,5'b01000, 0,1,4'd0,4'h5,2'd1)); // invalid barcode
        for (int i = 0; i < EH - 1; i++)
            vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 7,5'b00000, 0,1,4'd0,4'h5,2'd1));
        vq.push_back(v(0,0,0,0,0,0, 4'h0,1, 1,5'b00000, 0,1,4'd0,4'h5,2'd0));

        foreach (vq[i]) begin
            cmd_select = vq[i].cmd; sw_interactive = vq[i].swi; sw_edit = vq[i].swe;
            barcode_complete = vq[i].comp; product_valid = vq[i].valid; basket_ack = vq[i].ack;
            key_pulse = vq[i].keys; basket_count = vq[i].bcnt;
            step();
            chk($sformatf("vec%0d", i),
                64'({state_o, digit_push, barcode_clear, dir_en, dir_clear, end_shopping,
                     basket_req, basket_op, quantity_out, product_id_out, err_code}),
                64'({vq[i].e_state, vq[i].e_strb, vq[i].e_breq, vq[i].e_bop,
                     vq[i].e_qty, vq[i].e_pid, vq[i].e_err}));
        end
        idle_inputs();

        // Quantity timeout, then early exit from ERROR by select.
        step();
        barcode_complete = 1; product_valid = 1; cmd_select = 1; step();
        cmd_select = 0;
        for (int i = 0; i < QT - 1; i++) step();
        chk("qty_wait_state", 64'(state_o), 64'd4);
        step();
        chk("qty_timeout", 64'({state_o, err_code}), 64'({4'd7, 2'b11}));
        cmd_select = 1; step();
        chk("error_early_exit", 64'({state_o, err_code}), 64'({4'd1, 2'b00}));

        // Key arriving on the expiry cycle wins.
        cmd_select = 0; step();
        cmd_select = 1; step();
        cmd_select = 0;
        for (int i = 0; i < QT - 1; i++) step();
        key_pulse = 4'b0010; step();
        key_pulse = 4'b0000;
        chk("key_on_expiry", 64'({state_o, quantity_out, basket_req, err_code}), 64'({4'd5, 4'd2, 1'b1, 2'b00}));
        basket_ack = 1; step();
        basket_ack = 0;

        // Full basket goes to ERROR without any request.
        basket_count = 4'd8; step();
        cmd_select = 1; step();
        cmd_select = 0; step();
        chk("basket_full", 64'({state_o, err_code, basket_req}), 64'({4'd7, 2'b10, 1'b0}));
        cmd_select = 1; step();
        cmd_select = 0; basket_count = 4'd1;

        // Reset in the middle of a commit.
        step();
        cmd_select = 1; step();
        cmd_select = 0; key_pulse = 4'b0001; step();
        key_pulse = 4'b0000;
        chk("commit_req", 64'({state_o, basket_req}), 64'({4'd5, 1'b1}));
        RESET = 1; step();
        chk("reset_mid_commit", 64'(dut_outs()), 64'd0);
        RESET = 0;

        for (int n = 0; n < 4000; n++) begin
            RESET = ($urandom_range(0, 299) == 0);
            cmd_select = ($urandom_range(0, 5) == 0);
            key_pulse = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if ($urandom_range(0, 15) == 0) sw_interactive = ~sw_interactive;
            if ($urandom_range(0, 15) == 0) sw_edit = ~sw_edit;
            if ($urandom_range(0, 7) == 0) barcode_complete = ~barcode_complete;
            product_valid = ($urandom_range(0, 3) != 0);
            product_id_bc = 4'($urandom);
            product_id_dir = 4'($urandom);
            basket_count = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 7));
            basket_ack = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
